// File: rtl/serial_channel_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_channel_bridge_if
// Brief    : Bundles the UART-side byte streams, the per-channel agent
//            reward/action streams and the error counters of the bridge.
//            The "slave" modport is the bridge's own view; "master" is the
//            environment that surrounds it.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_channel_bridge_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int ERR_BITS = 8
);
    // Receive core -> bridge
    logic                        rx_stb;
    logic [7:0]                  rx_dat;
    logic                        rx_err;
    logic                        rx_rdy;
    // Bridge -> transmit core
    logic                        tx_stb;
    logic [7:0]                  tx_dat;
    logic                        tx_rdy;
    // Bridge -> agents (reward path)
    logic [CHANNELS-1:0]         reward_valid;
    logic [CHANNELS*WIDTH-1:0]   reward_data;
    logic [CHANNELS-1:0]         reward_ready;
    // Agents -> bridge (action path)
    logic [CHANNELS-1:0]         action_valid;
    logic [CHANNELS*WIDTH-1:0]   action_data;
    logic [CHANNELS-1:0]         action_ready;
    // Error accounting
    logic [ERR_BITS-1:0]         rx_err_count;
    logic [ERR_BITS-1:0]         bad_chan_count;

    modport slave (
        input  rx_stb, rx_dat, rx_err, tx_rdy, reward_ready, action_valid, action_data,
        output rx_rdy, tx_stb, tx_dat, reward_valid, reward_data, action_ready,
               rx_err_count, bad_chan_count
    );

    modport master (
        output rx_stb, rx_dat, rx_err, tx_rdy, reward_ready, action_valid, action_data,
        input  rx_rdy, tx_stb, tx_dat, reward_valid, reward_data, action_ready,
               rx_err_count, bad_chan_count
    );
endinterface
`default_nettype wire

// File: rtl/serial_channel_bridge.sv
`default_nettype none
// ============================================================================
// Module   : serial_channel_bridge
// Brief    : Multiplexes CHANNELS agent reward/action streams over one
//            byte-wide UART link. Frames are a channel-index header byte
//            followed by WIDTH/8 payload bytes, LSB first. Receive side
//            demultiplexes rewards; transmit side round-robin arbitrates
//            actions. Saturating counters track rx errors and bad headers.
// Revision : 1.0 - initial release
// ============================================================================
module serial_channel_bridge #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int ERR_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_channel_bridge_if.slave bus
);
    localparam int BYTES = WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [IDX_W-1:0]    c_last_idx = IDX_W'(BYTES - 1);
    localparam logic [IDX_W-1:0]    c_idx_one  = IDX_W'(1);
    localparam logic [8:0]          c_chan_lim = 9'(CHANNELS);
    localparam logic [CH_W-1:0]     c_last_ch  = CH_W'(CHANNELS - 1);
    localparam logic [ERR_BITS-1:0] c_err_max  = '1;
    localparam logic [ERR_BITS-1:0] c_err_one  = ERR_BITS'(1);

    localparam logic [1:0] c_rx_header  = 2'd0;
    localparam logic [1:0] c_rx_payload = 2'd1;
    localparam logic [1:0] c_rx_discard = 2'd2;
    localparam logic [1:0] c_rx_deliver = 2'd3;

    localparam logic [1:0] c_tx_idle    = 2'd0;
    localparam logic [1:0] c_tx_header  = 2'd1;
    localparam logic [1:0] c_tx_payload = 2'd2;

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    logic [1:0]          r_rx_state;
    logic [CH_W-1:0]     r_rx_ch;
    logic [IDX_W-1:0]    r_rx_idx;
    logic [WIDTH-1:0]    r_rx_asm;
    logic [ERR_BITS-1:0] r_rx_err_cnt;
    logic [ERR_BITS-1:0] r_bad_cnt;

    logic                w_rx_rdy;
    logic                w_rx_fire;
    logic                w_hdr_ok;
    logic                w_reward_take;
    logic [CHANNELS-1:0] w_reward_valid;

    // The bridge only stalls the receiver while a reward is waiting to be taken;
    // bit 7 of a header makes it exceed every legal channel count.
    assign w_rx_rdy      = (r_rx_state != c_rx_deliver);
    assign w_rx_fire     = bus.rx_stb && w_rx_rdy;
    assign w_hdr_ok      = ({1'b0, bus.rx_dat} < c_chan_lim);
    assign w_reward_take = (r_rx_state == c_rx_deliver) && bus.reward_ready[r_rx_ch];

    // Frame parser: header decode, payload assembly, bad-frame discard, error resync
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state   <= c_rx_header;
            r_rx_ch      <= '0;
            r_rx_idx     <= '0;
            r_rx_asm     <= '0;
            r_rx_err_cnt <= '0;
            r_bad_cnt    <= '0;
        end else if (w_rx_fire && bus.rx_err) begin
            if (r_rx_err_cnt != c_err_max) begin
                r_rx_err_cnt <= r_rx_err_cnt + c_err_one;
            end
            r_rx_state <= c_rx_header;
        end else if (w_rx_fire) begin
            case (r_rx_state)
                c_rx_header: begin
                    r_rx_idx <= '0;
                    if (w_hdr_ok) begin
                        r_rx_ch    <= bus.rx_dat[CH_W-1:0];
                        r_rx_state <= c_rx_payload;
                    end else begin
                        if (r_bad_cnt != c_err_max) begin
                            r_bad_cnt <= r_bad_cnt + c_err_one;
                        end
                        r_rx_state <= c_rx_discard;
                    end
                end
                c_rx_payload: begin
                    r_rx_asm[{r_rx_idx, 3'b000} +: 8] <= bus.rx_dat;
                    if (r_rx_idx == c_last_idx) begin
                        r_rx_state <= c_rx_deliver;
                    end else begin
                        r_rx_idx <= r_rx_idx + c_idx_one;
                    end
                end
                c_rx_discard: begin
                    if (r_rx_idx == c_last_idx) begin
                        r_rx_state <= c_rx_header;
                    end else begin
                        r_rx_idx <= r_rx_idx + c_idx_one;
                    end
                end
                default: ;
            endcase
        end else if (w_reward_take) begin
            r_rx_state <= c_rx_header;
        end
    end

    // Reward valid is raised only on the channel named by the frame header
    always_comb begin
        w_reward_valid = '0;
        if (r_rx_state == c_rx_deliver) begin
            w_reward_valid[r_rx_ch] = 1'b1;
        end
    end

    // The assembled payload is broadcast; only the valid bit selects a channel
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_reward_rep
        assign bus.reward_data[gi*WIDTH +: WIDTH] = r_rx_asm;
    end

    assign bus.rx_rdy         = w_rx_rdy;
    assign bus.reward_valid   = w_reward_valid;
    assign bus.rx_err_count   = r_rx_err_cnt;
    assign bus.bad_chan_count = r_bad_cnt;

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    logic [1:0]          r_tx_state;
    logic [CH_W-1:0]     r_tx_ch;
    logic [IDX_W-1:0]    r_tx_idx;
    logic [WIDTH-1:0]    r_tx_data;
    logic [CH_W-1:0]     r_rr_last;

    logic [CH_W:0]       w_pick;
    logic [CH_W-1:0]     w_grant;
    logic                w_grant_ok;
    logic                w_tx_stb;
    logic                w_tx_fire;
    logic [7:0]          w_tx_dat;
    logic [CHANNELS-1:0] w_action_ready;

    // Returns {found, channel}: first requester after 'last', wrapping around.
    // Scanning from the farthest offset down lets the nearest one win.
    function automatic logic [CH_W:0] rr_pick(input logic [CHANNELS-1:0] req,
                                              input logic [CH_W-1:0]     last);
        logic [CH_W:0] pick;
        logic [8:0]    cand;
        pick = '0;
        for (int i = CHANNELS; i >= 1; i--) begin
            cand = 9'(last) + 9'(i);
            if (cand >= c_chan_lim) begin
                cand = cand - c_chan_lim;
            end
            if (req[cand[CH_W-1:0]]) begin
                pick = {1'b1, cand[CH_W-1:0]};
            end
        end
        return pick;
    endfunction

    assign w_pick     = rr_pick(bus.action_valid, r_rr_last);
    assign w_grant    = w_pick[CH_W-1:0];
    assign w_grant_ok = (r_tx_state == c_tx_idle) && w_pick[CH_W];
    assign w_tx_stb   = (r_tx_state != c_tx_idle);
    assign w_tx_fire  = w_tx_stb && bus.tx_rdy;

    // Grant is combinational so the agent sees its accept in the arbitration cycle
    always_comb begin
        w_action_ready = '0;
        if (w_grant_ok) begin
            w_action_ready[w_grant] = 1'b1;
        end
    end

    // Byte presented to the transmit core: header index, then latched payload
    always_comb begin
        w_tx_dat = '0;
        case (r_tx_state)
            c_tx_header:  w_tx_dat[CH_W-1:0] = r_tx_ch;
            c_tx_payload: w_tx_dat = r_tx_data[{r_tx_idx, 3'b000} +: 8];
            default:      w_tx_dat = '0;
        endcase
    end

    // Frame serializer: latch the granted action, then emit header and payload
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= c_tx_idle;
            r_tx_ch    <= '0;
            r_tx_idx   <= '0;
            r_tx_data  <= '0;
            r_rr_last  <= c_last_ch;
        end else begin
            case (r_tx_state)
                c_tx_idle: begin
                    if (w_grant_ok) begin
                        r_tx_data  <= bus.action_data[w_grant*WIDTH +: WIDTH];
                        r_tx_ch    <= w_grant;
                        r_rr_last  <= w_grant;
                        r_tx_state <= c_tx_header;
                    end
                end
                c_tx_header: begin
                    if (w_tx_fire) begin
                        r_tx_idx   <= '0;
                        r_tx_state <= c_tx_payload;
                    end
                end
                c_tx_payload: begin
                    if (w_tx_fire) begin
                        if (r_tx_idx == c_last_idx) begin
                            r_tx_state <= c_tx_idle;
                        end else begin
                            r_tx_idx <= r_tx_idx + c_idx_one;
                        end
                    end
                end
                default: r_tx_state <= c_tx_idle;
            endcase
        end
    end

    assign bus.tx_stb       = w_tx_stb;
    assign bus.tx_dat       = w_tx_dat;
    assign bus.action_ready = w_action_ready;
endmodule
`default_nettype wire

// File: tb/tb_serial_channel_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_channel_bridge
// Brief    : Scoreboard bench for serial_channel_bridge (4 channels, 16 bit).
//            Stimulus pushes expected rewards/bytes into queues; a negedge
//            monitor pops and compares whenever the bridge presents output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_channel_bridge;
    localparam int CH     = 4;
    localparam int W      = 16;
    localparam int EB     = 8;
    localparam int NB     = W / 8;
    localparam int CNTMAX = (1 << EB) - 1;

    typedef struct {
        int           ch;
        logic [W-1:0] data;
    } rew_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_channel_bridge_if #(.CHANNELS(CH), .WIDTH(W), .ERR_BITS(EB)) bus ();

    serial_channel_bridge #(.CHANNELS(CH), .WIDTH(W), .ERR_BITS(EB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    rew_t       rew_q[$];
    logic [7:0] tx_q[$];
    int         grant_log[$];
    int         model_rr = CH - 1;
    int         exp_rx_err = 0;
    int         exp_bad = 0;
    bit         rx_done = 0;

    int           m_g;
    logic [W-1:0] m_d;
    logic [7:0]   m_b;
    rew_t         m_e;
    bit           prev_stall = 0;
    logic [7:0]   prev_dat = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got timeout, expected handshake (t=%0t)", name, $time);
    endtask

    // Round robin from the specification: first requester after the last grant
    function automatic int model_pick(input logic [CH-1:0] v, input int last);
        for (int k = 1; k <= CH; k++) begin
            if (v[(last + k) % CH]) return (last + k) % CH;
        end
        return -1;
    endfunction

    // Monitor: compares everything the bridge presents against the queues
    always @(negedge clk) begin
        if (rst) begin
            rew_q.delete();
            tx_q.delete();
            model_rr   = CH - 1;
            prev_stall = 0;
        end else begin
            if (bus.action_ready != 0) grant_log.push_back(int'(bus.action_ready));
            if (tx_q.size() == 0) begin
                if (bus.action_valid != 0) begin
                    m_g = model_pick(bus.action_valid, model_rr);
                    chk("grant", 64'(bus.action_ready), 64'(1) << m_g);
                    m_d = bus.action_data[m_g*W +: W];
                    tx_q.push_back(8'(m_g));
                    for (int i = 0; i < NB; i++) tx_q.push_back(m_d[i*8 +: 8]);
                    model_rr = m_g;
                end else begin
                    chk("no_grant_idle", 64'(bus.action_ready), 64'(0));
                end
            end else begin
                chk("no_grant_busy", 64'(bus.action_ready), 64'(0));
            end

            if (prev_stall) begin
                chk("tx_hold_stb", 64'(bus.tx_stb), 64'(1));
                chk("tx_hold_dat", 64'(bus.tx_dat), 64'(prev_dat));
            end
            if (bus.tx_stb) begin
                if (tx_q.size() == 0) begin
                    chk("tx_unexpected_stb", 64'(bus.tx_stb), 64'(0));
                end else if (bus.tx_rdy) begin
                    m_b = tx_q.pop_front();
                    chk("tx_byte", 64'(bus.tx_dat), 64'(m_b));
                end
            end
            prev_stall = bus.tx_stb && !bus.tx_rdy;
            prev_dat   = bus.tx_dat;

            if (bus.reward_valid != 0) begin
                if (rew_q.size() == 0) begin
                    chk("reward_unexpected", 64'(bus.reward_valid), 64'(0));
                end else begin
                    chk("reward_onehot", 64'(bus.reward_valid), 64'(1) << rew_q[0].ch);
                    chk("rx_rdy_in_deliver", 64'(bus.rx_rdy), 64'(0));
                    if ((bus.reward_valid & bus.reward_ready) != 0) begin
                        m_e = rew_q.pop_front();
                        for (int j = 0; j < CH; j++)
                            chk("reward_data", 64'(bus.reward_data[j*W +: W]), 64'(m_e.data));
                    end
                end
            end
        end
    end

    // All stimulus tasks start and end just after a rising edge
    task automatic send_byte(input logic [7:0] b, input logic err);
        bit ok = 0;
        bus.rx_stb = 1'b1;
        bus.rx_dat = b;
        bus.rx_err = err;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            ok = bus.rx_rdy;
            @(posedge clk);
            #1;
        end
        if (!ok) note_fail("rx_timeout");
        bus.rx_stb = 1'b0;
        bus.rx_err = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [W-1:0] data, input int errpos);
        logic [7:0] b[NB+1];
        rew_t e;
        if (errpos >= 0) begin
            if (exp_rx_err < CNTMAX) exp_rx_err++;
        end else if (int'(hdr) >= CH) begin
            if (exp_bad < CNTMAX) exp_bad++;
        end else begin
            e.ch   = int'(hdr);
            e.data = data;
            rew_q.push_back(e);
        end
        b[0] = hdr;
        for (int i = 0; i < NB; i++) b[i+1] = data[i*8 +: 8];
        for (int i = 0; i <= NB; i++) begin
            send_byte(b[i], i == errpos);
            if (i == errpos) break;
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((rew_q.size() != 0 || tx_q.size() != 0) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 200) note_fail("drain_timeout");
    endtask

    task automatic check_counters(input string tag);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_rx_err_count"}, 64'(bus.rx_err_count), 64'(exp_rx_err));
        chk({tag, "_bad_chan_count"}, 64'(bus.bad_chan_count), 64'(exp_bad));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_rx_err = 0;
        exp_bad    = 0;
        @(negedge clk);
        chk("rst_rx_rdy", 64'(bus.rx_rdy), 64'(1));
        chk("rst_tx_stb", 64'(bus.tx_stb), 64'(0));
        chk("rst_tx_dat", 64'(bus.tx_dat), 64'(0));
        chk("rst_reward_valid", 64'(bus.reward_valid), 64'(0));
        chk("rst_action_ready", 64'(bus.action_ready), 64'(0));
        chk("rst_rx_err_count", 64'(bus.rx_err_count), 64'(0));
        chk("rst_bad_chan_count", 64'(bus.bad_chan_count), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n);
        int k = 0;
        while (grant_log.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) note_fail("grant_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst              = 1'b1;
        bus.rx_stb       = 1'b0;
        bus.rx_dat       = '0;
        bus.rx_err       = 1'b0;
        bus.tx_rdy       = 1'b0;
        bus.reward_ready = '0;
        bus.action_valid = '0;
        bus.action_data  = '0;
        do_reset();

        // Reward delivered one cycle after the last byte; receiver stalls until taken
        send_frame(8'h02, 16'h1234, -1);
        @(negedge clk);
        chk("t1_reward_valid", 64'(bus.reward_valid), 64'(4'b0100));
        chk("t1_reward_data", 64'(bus.reward_data[2*W +: W]), 64'(16'h1234));
        repeat (3) begin
            @(negedge clk);
            chk("t1_rx_rdy_low", 64'(bus.rx_rdy), 64'(0));
        end
        @(posedge clk);
        #1 bus.reward_ready = 4'b1111;
        drain();

        // Bad headers are counted and discarded, then a good frame goes through
        send_frame(8'h07, 16'hBBAA, -1);
        check_counters("t2a");
        send_frame(8'h82, 16'h5A5A, -1);
        send_frame(8'h00, 16'h0001, -1);
        drain();
        check_counters("t2b");

        // Errored bytes abandon the frame and resync on the next header
        send_frame(8'h01, 16'h5566, 2);
        check_counters("t4a");
        send_frame(8'h03, 16'h7788, 1);
        send_frame(8'h01, 16'hC3A5, -1);
        drain();
        check_counters("t4b");

        // Held requests on 0,1,3 from the reset arbitration state
        grant_log.delete();
        bus.tx_rdy = 1'b1;
        bus.action_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        bus.action_valid = 4'b1011;
        wait_grants(4);
        bus.action_valid = '0;
        chk("t3_grant0", 64'(grant_log[0]), 64'(4'b0001));
        chk("t3_grant1", 64'(grant_log[1]), 64'(4'b0010));
        chk("t3_grant2", 64'(grant_log[2]), 64'(4'b1000));
        chk("t3_grant3", 64'(grant_log[3]), 64'(4'b0001));
        drain();

        // Transmitter back-pressured in the header
        bus.tx_rdy = 1'b0;
        bus.action_data[2*W +: W] = 16'hBEEF;
        bus.action_valid = 4'b0100;
        grant_log.delete();
        wait_grants(1);
        bus.action_valid = '0;
        repeat (10) begin
            @(negedge clk);
            chk("t5_tx_stb", 64'(bus.tx_stb), 64'(1));
            chk("t5_tx_dat", 64'(bus.tx_dat), 64'(8'h02));
        end
        @(posedge clk);
        #1 bus.tx_rdy = 1'b1;
        drain();

        // Reset with both directions mid-payload
        bus.action_valid = 4'b0010;
        grant_log.delete();
        wait_grants(1);
        bus.action_valid = '0;
        @(posedge clk);
        #1 bus.tx_rdy = 1'b0;
        send_byte(8'h02, 1'b0);
        send_byte(8'h34, 1'b0);
        do_reset();
        bus.tx_rdy = 1'b1;
        grant_log.delete();
        bus.action_valid = 4'b1111;
        wait_grants(4);
        bus.action_valid = '0;
        chk("t6_first_grant", 64'(grant_log[0]), 64'(4'b0001));
        drain();

        // Counter saturation
        for (int i = 0; i < CNTMAX + 5; i++) send_frame(8'h00, 16'h0000, 0);
        check_counters("sat_rx_err");
        for (int i = 0; i < CNTMAX + 3; i++) send_frame(8'($urandom_range(CH, 255)), 16'($urandom), -1);
        check_counters("sat_bad");
        do_reset();

        // Randomised concurrent traffic on both directions
        rx_done = 0;
        fork
            begin
                for (int f = 0; f < 150; f++) begin
                    int r;
                    r = int'($urandom_range(0, 9));
                    if (r == 0)
                        send_frame(8'($urandom_range(0, CH-1)), 16'($urandom), int'($urandom_range(0, NB)));
                    else if (r == 1)
                        send_frame(8'($urandom_range(CH, 255)), 16'($urandom), -1);
                    else
                        send_frame(8'($urandom_range(0, CH-1)), 16'($urandom), -1);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rx_done = 1;
            end
            begin
                int          cyc;
                logic [CH-1:0] acc;
                cyc = 0;
                while (!(rx_done && bus.action_valid == 0 && tx_q.size() == 0 && rew_q.size() == 0)
                       && cyc < 30000) begin
                    @(negedge clk);
                    acc = bus.action_valid & bus.action_ready;
                    @(posedge clk);
                    #1;
                    cyc++;
                    bus.tx_rdy       = ($urandom_range(0, 3) != 0);
                    bus.reward_ready = CH'($urandom);
                    for (int c = 0; c < CH; c++) begin
                        if (acc[c]) bus.action_valid[c] = 1'b0;
                        if (!rx_done && !bus.action_valid[c] && $urandom_range(0, 2) == 0) begin
                            bus.action_valid[c]       = 1'b1;
                            bus.action_data[c*W +: W] = W'($urandom);
                        end
                    end
                end
                if (cyc >= 30000) note_fail("random_drain_timeout");
            end
        join
        bus.reward_ready = 4'b1111;
        check_counters("random");
        chk("end_reward_queue", 64'(rew_q.size()), 64'(0));
        chk("end_tx_queue", 64'(tx_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
